// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encodings and default width.
package serial_adder_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int ALU_WIDTH = 8;

   // Two's-complement overflow from the carries into and out of the MSB.
   function automatic logic ovf_calc(input logic c_into_msb, input logic c_out_msb);
      return c_into_msb ^ c_out_msb;
   endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder built from two half adders and an OR; used as the
// per-bit cell of serial_adder.
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic c_out
);
   assign sum   = a ^ b;
   assign c_out = a & b;
endmodule

module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);
   logic w_s1;
   logic w_c1;
   logic w_c2;

   half_adder u_ha0 (.a(a),    .b(b),    .sum(w_s1), .c_out(w_c1));
   half_adder u_ha1 (.a(w_s1), .b(c_in), .sum(sum),  .c_out(w_c2));

   assign c_out = w_c1 | w_c2;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, one bit per clock LSB first, start/done handshake.
// Define SERIAL_ADDER_SUB_EN to add the `sub` port (A - B via ~B + 1).
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_c_out;
   logic             r_ovf;
   logic             r_busy;
   logic             r_done;

   logic [WIDTH-1:0] w_b_load;
   logic             w_c_load;
   logic             w_fa_sum;
   logic             w_fa_cout;

   full_adder u_fa (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .c_in (r_carry),
      .sum  (w_fa_sum),
      .c_out(w_fa_cout)
   );

   // Operand B and carry values loaded on accept (inverted B and carry 1 when subtracting).
   always_comb begin
      w_b_load = b;
      w_c_load = c_in;
`ifdef SERIAL_ADDER_SUB_EN
      if (sub) begin
         w_b_load = ~b;
         w_c_load = 1'b1;
      end else begin
         w_b_load = b;
         w_c_load = c_in;
      end
`endif
   end

   // FSM, shift registers, carry register, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_c_out <= 1'b0;
         r_ovf   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_state <= ST_RUN;
                  r_a     <= a;
                  r_b     <= w_b_load;
                  r_carry <= w_c_load;
                  r_cnt   <= '0;
                  r_sum   <= '0;
                  r_c_out <= 1'b0;
                  r_ovf   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
               end
            end
            ST_RUN: begin
               r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
               r_a     <= {1'b0, r_a[WIDTH-1:1]};
               r_b     <= {1'b0, r_b[WIDTH-1:1]};
               r_carry <= w_fa_cout;
               if (r_cnt == LAST_BIT) begin
                  r_state <= ST_DONE;
                  r_c_out <= w_fa_cout;
                  r_ovf   <= ovf_calc(r_carry, w_fa_cout);
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt   <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign sum   = r_sum;
   assign c_out = r_c_out;
   assign ovf   = r_ovf;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule
